// File: rtl/syn_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty offset, occupancy
// count, sticky overflow/underflow flags and optional first-word-fall-through.
module syn_fifo_prog #(
  parameter int FIFO_ENTRIES = 1024,
  parameter int DATA_WIDTH   = 16,
  parameter int FWFT         = 0,
  parameter int AF_AE_OFFSET = 127
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                wr_i,
  input  logic                                rd_i,
  input  logic                                daf_i,
  input  logic                                oe_i,
  input  logic [DATA_WIDTH-1:0]               data_in_i,
  output logic [DATA_WIDTH-1:0]               data_out_o,
  output logic                                fifo_empty_o,
  output logic                                fifo_full_o,
  output logic                                half_full_o,
  output logic                                af_ae_o,
  output logic [$clog2(FIFO_ENTRIES):0]       level_o,
  output logic                                overflow_o,
  output logic                                underflow_o
);

  localparam int AW = $clog2(FIFO_ENTRIES);
  localparam logic [AW:0]   DEPTH   = (AW+1)'(FIFO_ENTRIES);
  localparam logic [AW:0]   HALF    = (AW+1)'(FIFO_ENTRIES / 2);
  localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW-1:0] OFF_MAX = AW'(FIFO_ENTRIES / 2 - 1);
  localparam logic [AW-1:0] OFF_RST = AW'(AF_AE_OFFSET);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_ENTRIES];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           level_q, level_d;
  logic [AW-1:0]         offset_q, offset_d;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  ovf_q, udf_q;
  logic                  empty, full, rd_acc, wr_acc;
  logic [DATA_WIDTH-1:0] data_sel;
  logic [AW:0]           offset_ext;

  always_comb begin
    empty  = (level_q == '0);
    full   = (level_q == DEPTH);
    rd_acc = rd_i & ~empty;
    // A read in the same cycle frees a slot, so a full FIFO still accepts the write.
    wr_acc = wr_i & ~daf_i & (~full | rd_acc);
    level_d = level_q;
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    offset_d = (data_in_i[AW-1:0] > OFF_MAX) ? OFF_MAX : data_in_i[AW-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wr_ptr_q] <= data_in_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      offset_q <= OFF_RST;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      level_q <= level_d;
      if (wr_acc) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (rd_acc) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
        dout_q   <= mem_q[rd_ptr_q];
      end
      if (daf_i) offset_q <= offset_d;
      if (wr_i & ~daf_i & full & ~rd_acc) ovf_q <= 1'b1;
      if (rd_i & empty) udf_q <= 1'b1;
    end
  end

  // In FWFT mode the head word is shown directly; dout_q keeps the last pop for when empty.
  always_comb begin
    data_sel   = ((FWFT != 0) && !empty) ? mem_q[rd_ptr_q] : dout_q;
    offset_ext = {1'b0, offset_q};
  end

  assign data_out_o   = oe_i ? data_sel : '0;
  assign fifo_empty_o = empty;
  assign fifo_full_o  = full;
  assign half_full_o  = (level_q >= HALF);
  assign af_ae_o      = (level_q <= offset_ext) || (level_q >= (DEPTH - offset_ext));
  assign level_o      = level_q;
  assign overflow_o   = ovf_q;
  assign underflow_o  = udf_q;

endmodule

// File: tb/tb_syn_fifo_prog.sv
// Scoreboard bench for syn_fifo_prog: a standard-mode instance driven through a
// reference model, plus a directed first-word-fall-through instance.
module tb_syn_fifo_prog;

  logic       clk;
  logic       rst_i, wr_i, rd_i, daf_i, oe_i;
  logic [7:0] din_i, dout_o;
  logic       empty_o, full_o, half_o, afae_o, ovf_o, udf_o;
  logic [4:0] level_o;

  logic       f_rst, f_wr, f_rd, f_daf, f_oe;
  logic [7:0] f_din, f_dout;
  logic       f_empty, f_full, f_half, f_afae, f_ovf, f_udf;
  logic [4:0] f_level;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb [$];
  int         mlvl;
  int         m_off;
  logic       m_ovf, m_udf;
  logic [7:0] m_dout;

  syn_fifo_prog #(.FIFO_ENTRIES(16), .DATA_WIDTH(8), .FWFT(0), .AF_AE_OFFSET(2)) u_std (
    .clk_i(clk), .rst_i(rst_i), .wr_i(wr_i), .rd_i(rd_i), .daf_i(daf_i), .oe_i(oe_i),
    .data_in_i(din_i), .data_out_o(dout_o), .fifo_empty_o(empty_o), .fifo_full_o(full_o),
    .half_full_o(half_o), .af_ae_o(afae_o), .level_o(level_o),
    .overflow_o(ovf_o), .underflow_o(udf_o)
  );

  syn_fifo_prog #(.FIFO_ENTRIES(16), .DATA_WIDTH(8), .FWFT(1), .AF_AE_OFFSET(2)) u_fwft (
    .clk_i(clk), .rst_i(f_rst), .wr_i(f_wr), .rd_i(f_rd), .daf_i(f_daf), .oe_i(f_oe),
    .data_in_i(f_din), .data_out_o(f_dout), .fifo_empty_o(f_empty), .fifo_full_o(f_full),
    .half_full_o(f_half), .af_ae_o(f_afae), .level_o(f_level),
    .overflow_o(f_ovf), .underflow_o(f_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check_eq("level", 32'(level_o), 32'(mlvl));
    check_eq("empty", 32'(empty_o), 32'(mlvl == 0));
    check_eq("full",  32'(full_o),  32'(mlvl == 16));
    check_eq("half",  32'(half_o),  32'(mlvl >= 8));
    check_eq("af_ae", 32'(afae_o),  32'((mlvl <= m_off) || (mlvl >= 16 - m_off)));
    check_eq("ovf",   32'(ovf_o),   32'(m_ovf));
    check_eq("udf",   32'(udf_o),   32'(m_udf));
    check_eq("dout",  32'(dout_o),  32'(oe_i ? m_dout : 8'h00));
  endtask

  task automatic tick(input logic w, input logic r, input logic d, input logic [7:0] din);
    logic racc, wacc;
    wr_i = w; rd_i = r; daf_i = d; din_i = din;
    racc = r && (mlvl != 0);
    wacc = w && !d && ((mlvl != 16) || racc);
    if (w && !d && mlvl == 16 && !racc) m_ovf = 1'b1;
    if (r && mlvl == 0) m_udf = 1'b1;
    if (racc) m_dout = sb.pop_front();
    if (wacc) sb.push_back(din);
    mlvl = mlvl + int'(wacc) - int'(racc);
    if (d) m_off = (din[3:0] > 4'd7) ? 7 : int'(din[3:0]);
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic rst_pulse(input logic w);
    rst_i = 1'b1; wr_i = w; rd_i = 1'b0; daf_i = 1'b0; din_i = 8'hEE;
    @(posedge clk); #1;
    rst_i = 1'b0; wr_i = 1'b0;
    sb.delete();
    mlvl = 0; m_off = 2; m_ovf = 1'b0; m_udf = 1'b0; m_dout = 8'h00;
    check_all();
  endtask

  task automatic ftick(input logic w, input logic r, input logic [7:0] din);
    f_wr = w; f_rd = r; f_din = din;
    @(posedge clk); #1;
    f_wr = 1'b0; f_rd = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; wr_i = 1'b0; rd_i = 1'b0; daf_i = 1'b0; oe_i = 1'b1; din_i = 8'h00;
    f_rst = 1'b1; f_wr = 1'b0; f_rd = 1'b0; f_daf = 1'b0; f_oe = 1'b1; f_din = 8'h00;

    rst_pulse(1'b0);
    tick(0, 0, 0, 8'h00);
    tick(0, 0, 0, 8'h00);

    // fill, overflow, drain in order, then one empty read
    for (int i = 1; i <= 16; i++) tick(1, 0, 0, 8'(i));
    tick(1, 0, 0, 8'hAA);
    for (int i = 0; i < 16; i++) tick(0, 1, 0, 8'h00);
    tick(0, 0, 0, 8'h00);
    tick(0, 1, 0, 8'h00);

    // full with simultaneous read/write across pointer wrap
    rst_pulse(1'b0);
    for (int i = 0; i < 16; i++) tick(1, 0, 0, 8'(8'h20 + i));
    for (int i = 0; i < 20; i++) tick(1, 1, 0, 8'(8'h40 + i));
    for (int i = 0; i < 16; i++) tick(0, 1, 0, 8'h00);

    // programmable offset 5, then clamp of 0x0F to 7 with a suppressed write
    rst_pulse(1'b0);
    tick(0, 0, 1, 8'h05);
    for (int i = 0; i < 16; i++) tick(1, 0, 0, 8'(8'h60 + i));
    tick(1, 0, 1, 8'h0F);
    for (int i = 0; i < 16; i++) tick(0, 1, 0, 8'h00);

    // output enable gating while reads continue
    rst_pulse(1'b0);
    for (int i = 0; i < 6; i++) tick(1, 0, 0, 8'(8'h90 + i));
    oe_i = 1'b0;
    for (int i = 0; i < 3; i++) tick(0, 1, 0, 8'h00);
    oe_i = 1'b1;
    for (int i = 0; i < 3; i++) tick(0, 1, 0, 8'h00);

    // reset mid-fill at level 9 with a write pending
    rst_pulse(1'b0);
    for (int i = 0; i < 9; i++) tick(1, 0, 0, 8'(8'hB0 + i));
    rst_pulse(1'b1);
    tick(0, 0, 0, 8'h00);

    // first-word-fall-through instance
    @(posedge clk); #1;
    f_rst = 1'b0;
    check_eq("f_rst_empty", 32'(f_empty), 32'd1);
    check_eq("f_rst_level", 32'(f_level), 32'd0);
    check_eq("f_rst_dout",  32'(f_dout),  32'h00);
    ftick(1, 0, 8'h3C);
    check_eq("f_wr_empty", 32'(f_empty), 32'd0);
    check_eq("f_wr_dout",  32'(f_dout),  32'h3C);
    ftick(0, 0, 8'h00);
    check_eq("f_hold_dout", 32'(f_dout), 32'h3C);
    ftick(0, 1, 8'h00);
    check_eq("f_pop_empty", 32'(f_empty), 32'd1);
    check_eq("f_pop_dout",  32'(f_dout),  32'h3C);
    check_eq("f_pop_udf",   32'(f_udf),   32'd0);
    ftick(1, 1, 8'h55);
    check_eq("f_rw_udf",   32'(f_udf),   32'd1);
    check_eq("f_rw_level", 32'(f_level), 32'd1);
    check_eq("f_rw_dout",  32'(f_dout),  32'h55);
    ftick(1, 0, 8'h66);
    ftick(1, 0, 8'h77);
    check_eq("f_w3_level", 32'(f_level), 32'd3);
    check_eq("f_w3_dout",  32'(f_dout),  32'h55);
    ftick(0, 1, 8'h00);
    check_eq("f_next_dout",  32'(f_dout),  32'h66);
    check_eq("f_next_level", 32'(f_level), 32'd2);
    ftick(0, 1, 8'h00);
    check_eq("f_next2_dout", 32'(f_dout), 32'h77);
    ftick(0, 1, 8'h00);
    check_eq("f_last_empty", 32'(f_empty), 32'd1);
    check_eq("f_last_dout",  32'(f_dout),  32'h77);
    f_oe = 1'b0;
    #1;
    check_eq("f_oe_dout", 32'(f_dout), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
